// File: rtl/queue_pkg.sv
// Shared defaults and the occupancy state encoding for the queue controller.
package queue_pkg;

    localparam int DEPTH_DEF = 16;
    localparam int DW_DEF    = 16;
    localparam int AW_DEF    = 4;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        ACTIVE = 2'b01,
        FULL   = 2'b10
    } q_state_t;

endpackage

// File: rtl/queue_ptr.sv
// Head/tail/count bookkeeping for the queue; storage itself lives outside.
// count_nxt exposes the next-edge occupancy so the parent can track state.
module queue_ptr
    import queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          enq,
    input  logic          deq,
    input  logic          flush,
    output logic [AW-1:0] head,
    output logic [AW-1:0] tail,
    output logic [AW:0]   count,
    output logic [AW:0]   count_nxt
);

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + AW'(1);
            if (deq) head_d = head_q + AW'(1);
            if (enq && !deq)      count_d = count_q + (AW+1)'(1);
            else if (!enq && deq) count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head      = head_q;
    assign tail      = tail_q;
    assign count     = count_q;
    assign count_nxt = count_d;

endmodule

// File: rtl/queue_ctrl.sv
// Queue controller over an external register file, with a registered output stage.
// Define QUEUE_CTRL_ERR_CNT_EN to add saturating overflow/underflow counters.
//
//   state  | meaning
//   EMPTY  | count == 0, nothing to load into the output stage
//   ACTIVE | 0 < count < DEPTH
//   FULL   | count == DEPTH, enqueue blocked
module queue_ctrl
    import queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,
    output logic [AW-1:0] rf_ra0,
    input  logic [DW-1:0] rf_rd0,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
`ifdef QUEUE_CTRL_ERR_CNT_EN
    ,
    output logic [7:0]    ovf_cnt,
    output logic [7:0]    udf_cnt
`endif
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    q_state_t      state_q, state_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [AW-1:0] head, tail;
    logic [AW:0]   count_nxt;
    logic          enq, load;

    // full/empty come from the state register, which mirrors the registered count.
    assign full     = (state_q == FULL);
    assign empty    = (state_q == EMPTY);
    assign in_ready = !full;

    assign enq  = rstn && !flush && in_valid && in_ready;
    assign load = !flush && (!out_valid_q || out_ready) && !empty;

    queue_ptr #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ptr (
        .clk       (clk),
        .rstn      (rstn),
        .enq       (enq),
        .deq       (load),
        .flush     (flush),
        .head      (head),
        .tail      (tail),
        .count     (count),
        .count_nxt (count_nxt)
    );

    assign rf_we  = enq;
    assign rf_wa  = tail;
    assign rf_wd  = in_data;
    assign rf_ra0 = head;

    always_comb begin
        state_d = ACTIVE;
        if (count_nxt == '0)          state_d = EMPTY;
        else if (count_nxt == DEPTH_C) state_d = FULL;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = rf_rd0;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef QUEUE_CTRL_ERR_CNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;
    logic [7:0] udf_cnt_q, udf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        udf_cnt_d = udf_cnt_q;
        if (flush) begin
            ovf_cnt_d = '0;
            udf_cnt_d = '0;
        end else begin
            if (in_valid && full && ovf_cnt_q != 8'hFF)
                ovf_cnt_d = ovf_cnt_q + 8'd1;
            if (out_ready && !out_valid_q && empty && udf_cnt_q != 8'hFF)
                udf_cnt_d = udf_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ovf_cnt_q <= '0;
            udf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            udf_cnt_q <= udf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
    assign udf_cnt = udf_cnt_q;
`endif

endmodule

// File: tb/tb_queue_ctrl.sv
// Directed bench for queue_ctrl: vector table plus hand sequences for fill, wrap, flush, reset.
module tb_queue_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [15:0] rf_wd;
    logic [3:0]  rf_ra0;
    logic [15:0] rf_rd0;
    logic [4:0]  count;
    logic        full;
    logic        empty;
`ifdef QUEUE_CTRL_ERR_CNT_EN
    logic [7:0]  ovf_cnt;
    logic [7:0]  udf_cnt;
`endif

    always #5 clk = ~clk;

    queue_ctrl dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .rf_ra0    (rf_ra0),
        .rf_rd0    (rf_rd0),
        .count     (count),
        .full      (full),
        .empty     (empty)
`ifdef QUEUE_CTRL_ERR_CNT_EN
        ,
        .ovf_cnt   (ovf_cnt),
        .udf_cnt   (udf_cnt)
`endif
    );

    // External register file: synchronous write, combinational read-first.
    logic [15:0] mem [16];
    always @(posedge clk) if (rf_we) mem[rf_wa] <= rf_wd;
    assign rf_rd0 = mem[rf_ra0];

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q [$];
    logic [3:0]  tail_m = 4'd0;
    int pushes = 0;
    int pops   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle with the scoreboard: inputs driven just after an edge,
    // handshakes judged before the next edge.
    task automatic step(input logic iv, input logic [15:0] d, input logic ordy, input logic fl);
        logic [15:0] w;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        if (!fl && out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                chk("pop_underflow", 32'd1, 32'd0);
            end else begin
                w = exp_q.pop_front();
                chk("out_data", out_data, w);
                pops++;
            end
        end
        if (fl || !(iv && in_ready)) begin
            chk("rf_we_idle", rf_we, 1'b0);
        end else begin
            chk("rf_we", rf_we, 1'b1);
            chk("rf_wa", rf_wa, tail_m);
            chk("rf_wd", rf_wd, d);
            exp_q.push_back(d);
            pushes++;
            tail_m = tail_m + 4'd1;
        end
        if (fl) begin
            exp_q.delete();
            tail_m = 4'd0;
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        iv;
        logic [15:0] d;
        logic        ordy;
        logic        exp_we;
        logic [3:0]  exp_wa;
        logic [4:0]  exp_cnt;
        logic        exp_ov;
        logic [15:0] exp_od;
    } vec_t;

    vec_t vecs [9];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h0;
        vecs[0] = '{1'b1, 16'h1111, 1'b1, 1'b1, 4'd0, 5'd1, 1'b0, 16'h0000};
        vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd1, 5'd0, 1'b1, 16'h1111};
        vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd1, 5'd0, 1'b0, 16'h1111};
        vecs[3] = '{1'b1, 16'h2222, 1'b0, 1'b1, 4'd1, 5'd1, 1'b0, 16'h1111};
        vecs[4] = '{1'b1, 16'h3333, 1'b0, 1'b1, 4'd2, 5'd1, 1'b1, 16'h2222};
        vecs[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd3, 5'd1, 1'b1, 16'h2222};
        vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd3, 5'd0, 1'b1, 16'h3333};
        vecs[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd3, 5'd0, 1'b0, 16'h3333};
        vecs[8] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd3, 5'd0, 1'b0, 16'h3333};

        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_count", count, 5'd0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 16'h0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_rf_we", rf_we, 1'b0);
        rstn = 1'b1;

        // Basic latency, hold and simultaneous enqueue/load behaviour.
        for (int i = 0; i < 9; i++) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].d;
            out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), in_ready, 1'b1);
            chk($sformatf("v%0d_rf_we", i), rf_we, vecs[i].exp_we);
            if (vecs[i].exp_we) chk($sformatf("v%0d_rf_wa", i), rf_wa, vecs[i].exp_wa);
            @(posedge clk); #1;
            chk($sformatf("v%0d_count", i), count, vecs[i].exp_cnt);
            chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].exp_ov);
            chk($sformatf("v%0d_out_data", i), out_data, vecs[i].exp_od);
        end

        // Fill: the output stage takes the first word, so 17 writes reach count=16.
        step(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        chk("fill_full", full, 1'b1);
        chk("fill_in_ready", in_ready, 1'b0);
        chk("fill_count", count, 5'd16);
        chk("fill_out_data", out_data, 16'h0000);
        step(1'b1, 16'hDEAD, 1'b0, 1'b0);
        chk("fill_count_hold", count, 5'd16);

        // Streaming from full: order preserved across pointer wrap.
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0);
            chk("stream_count_range", (count >= 5'd15 && count <= 5'd16), 1'b1);
        end
        for (int i = 0; i < 40 && (out_valid || !empty); i++) step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("drain_done", (out_valid || !empty), 1'b0);
        chk("no_loss", exp_q.size(), 0);
        chk("push_pop_match", pops, pushes);

        // Flush with count=7 and a word waiting in the output stage.
        for (int i = 0; i < 8; i++) step(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
        chk("pre_flush_count", count, 5'd7);
        chk("pre_flush_out_valid", out_valid, 1'b1);
        step(1'b1, 16'hBEEF, 1'b0, 1'b1);
        chk("flush_count", count, 5'd0);
        chk("flush_empty", empty, 1'b1);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_next_wa", rf_wa, 4'd0);
        step(1'b1, 16'h0300, 1'b0, 1'b0);

        // Reset mid-stream with count=5.
        for (int i = 0; i < 20 && count != 5'd5; i++) step(1'b1, 16'h0400 + 16'(i), 1'b0, 1'b0);
        chk("pre_rst_count", count, 5'd5);
        rstn = 1'b0; in_valid = 1'b1; in_data = 16'h5555; out_ready = 1'b1;
        #1;
        chk("rst_mid_rf_we", rf_we, 1'b0);
        @(posedge clk); #1;
        chk("rst_mid_count", count, 5'd0);
        chk("rst_mid_empty", empty, 1'b1);
        chk("rst_mid_out_valid", out_valid, 1'b0);
        chk("rst_mid_out_data", out_data, 16'h0);
        chk("rst_mid_rf_wa", rf_wa, 4'd0);
        chk("rst_mid_rf_ra0", rf_ra0, 4'd0);
        chk("rst_mid_rf_we_hold", rf_we, 1'b0);
        rstn = 1'b1;
        exp_q.delete();
        tail_m = 4'd0;

`ifdef QUEUE_CTRL_ERR_CNT_EN
        for (int i = 0; i < 40 && !full; i++) step(1'b1, 16'h0600 + 16'(i), 1'b0, 1'b0);
        chk("ovf_full", full, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b1, 16'h0700, 1'b0, 1'b0);
        chk("ovf_saturated", ovf_cnt, 8'd255);
        chk("udf_idle", udf_cnt, 8'd0);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        chk("ovf_flushed", ovf_cnt, 8'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("udf_three", udf_cnt, 8'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
